m_alu_unit: RTL and testbench

M_ALU_UNIT -- requirements
Module: m_alu_unit

---
 rtl/m_alu_unit.sv | 113 +++++++++++
 tb/tb_m_alu_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/m_alu_unit.sv
// m_alu_unit: iterative RV64M multiply/divide unit with shift-add multiply and restoring divide
module m_alu_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic        is_word,
  input  logic [63:0] op_a,
  input  logic [63:0] op_b,
  input  logic        flush,
  output logic        mALU_runing,
  output logic        result_valid,
  output logic [63:0] result
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic w, hi, dv, rem_op, neg_q, neg_r;
  logic [5:0] cnt;
  logic [127:0] acc, mcand, acc_n, prod;
  logic [63:0] q, rem, dsr, q_n, rem_n, qv, rv, raw, fin;
  logic [64:0] rs, diff;
  logic hi_i, sgn_a, sgn_b, msb_a, msb_b, sa, sb, div_zero, ovf, special;
  logic [63:0] ax, bx, na, nb, ma, mb, sext_a, spec_res;
  always_comb begin
    hi_i = ~funct3[2] & ~is_word & (funct3[1:0] != 2'b00);
    sgn_a = hi_i ? (funct3[1:0] != 2'b11) : (funct3[2] & ~funct3[0]);
    sgn_b = hi_i ? (funct3[1:0] == 2'b01) : (funct3[2] & ~funct3[0]);
    msb_a = is_word ? op_a[31] : op_a[63];
    msb_b = is_word ? op_b[31] : op_b[63];
    sa = sgn_a & msb_a;
    sb = sgn_b & msb_b;
    ax = is_word ? {32'h0, op_a[31:0]} : op_a;
    bx = is_word ? {32'h0, op_b[31:0]} : op_b;
    na = -ax;
    nb = -bx;
    ma = sa ? (is_word ? {32'h0, na[31:0]} : na) : ax;
    mb = sb ? (is_word ? {32'h0, nb[31:0]} : nb) : bx;
    sext_a = is_word ? {{32{op_a[31]}}, op_a[31:0]} : op_a;
    div_zero = bx == 64'h0;
    ovf = funct3[2] & ~funct3[0] & msb_a
        & (is_word ? op_a[30:0] == 31'h0 : op_a[62:0] == 63'h0)
        & (is_word ? &op_b[31:0] : &op_b);
    special = funct3[2] & (div_zero | ovf);
    spec_res = div_zero ? (funct3[1] ? sext_a : '1) : (funct3[1] ? '0 : sext_a);
    acc_n = acc + (q[0] ? mcand : 128'h0);
    rs = {rem, q[63]};
    diff = rs - {1'b0, dsr};
    rem_n = diff[64] ? rs[63:0] : diff[63:0];
    q_n = {q[62:0], ~diff[64]};
    prod = neg_q ? -acc_n : acc_n;
    qv = neg_q ? -q_n : q_n;
    rv = neg_r ? -rem_n : rem_n;
    raw = dv ? (rem_op ? rv : qv) : (hi ? prod[127:64] : prod[63:0]);
    fin = w ? {{32{raw[31]}}, raw[31:0]} : raw;
    mALU_runing = (rst_n & (state == IDLE) & start & ~flush) | (state == CALC);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      result_valid <= 1'b0;
      result <= 64'h0;
      cnt <= 6'h0;
      acc <= 128'h0;
      mcand <= 128'h0;
      q <= 64'h0;
      rem <= 64'h0;
      dsr <= 64'h0;
      w <= 1'b0;
      hi <= 1'b0;
      dv <= 1'b0;
      rem_op <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (state == IDLE && start) begin
        w <= is_word;
        hi <= hi_i;
        dv <= funct3[2];
        rem_op <= funct3[1];
        neg_q <= sa ^ sb;
        neg_r <= sa;
        cnt <= is_word ? 6'd31 : 6'd63;
        acc <= 128'h0;
        mcand <= {64'h0, ma};
        q <= funct3[2] ? (is_word ? {ma[31:0], 32'h0} : ma) : mb;
        rem <= 64'h0;
        dsr <= mb;
        state <= special ? DONE : CALC;
        if (special) begin
          result <= spec_res;
          result_valid <= 1'b1;
        end
      end else if (state == CALC) begin
        acc <= acc_n;
        mcand <= mcand << 1;
        q <= dv ? q_n : q >> 1;
        rem <= dv ? rem_n : rem;
        cnt <= cnt - 6'd1;
        if (cnt == 6'd0) begin
          state <= DONE;
          result <= fin;
          result_valid <= 1'b1;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_m_alu_unit.sv
// tb_m_alu_unit: directed vectors against an arithmetic reference model checked every cycle
module tb_m_alu_unit;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, is_word = 1'b0, flush = 1'b0;
  logic [2:0] funct3 = 3'b000;
  logic [63:0] op_a = 64'h0, op_b = 64'h0;
  logic mALU_runing, result_valid;
  logic [63:0] result;
  int checks = 0, failures = 0;
  m_alu_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .is_word(is_word),
    .op_a(op_a), .op_b(op_b), .flush(flush), .mALU_runing(mALU_runing),
    .result_valid(result_valid), .result(result)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask
  function automatic logic [63:0] sx(input logic wd, input logic [63:0] v);
    return wd ? {{32{v[31]}}, v[31:0]} : v;
  endfunction
  function automatic logic [63:0] ref_res(input logic [2:0] f, input logic wd, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, r, mn;
    sa = sx(wd, a);
    sb = sx(wd, b);
    ua = wd ? {32'h0, a[31:0]} : a;
    ub = wd ? {32'h0, b[31:0]} : b;
    mn = wd ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    if (!f[2]) begin
      if (wd) begin
        p = {64'h0, ua} * {64'h0, ub};
        return sx(1'b1, p[63:0]);
      end
      if (f[1:0] == 2'b00) p = {64'h0, a} * {64'h0, b};
      else if (f[1:0] == 2'b01) p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
      else if (f[1:0] == 2'b10) p = {{64{a[63]}}, a} * {64'h0, b};
      else p = {64'h0, a} * {64'h0, b};
      return (f[1:0] == 2'b00) ? p[63:0] : p[127:64];
    end
    if (ub == 64'h0) r = f[1] ? sa : 64'hFFFF_FFFF_FFFF_FFFF;
    else if (!f[0] && sa == mn && sb == 64'hFFFF_FFFF_FFFF_FFFF) r = f[1] ? 64'h0 : sa;
    else if (!f[0]) r = f[1] ? sa % sb : sa / sb;
    else r = f[1] ? ua % ub : ua / ub;
    return sx(wd, r);
  endfunction
  function automatic int ref_lat(input logic [2:0] f, input logic wd, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] sa, sb, ub, mn;
    sa = sx(wd, a);
    sb = sx(wd, b);
    ub = wd ? {32'h0, b[31:0]} : b;
    mn = wd ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    if (f[2] && (ub == 64'h0 || (!f[0] && sa == mn && sb == 64'hFFFF_FFFF_FFFF_FFFF))) return 1;
    return wd ? 33 : 65;
  endfunction
  int cyc = 0, t0 = 0, lat = 0;
  bit act = 1'b0;
  logic [63:0] exp_r = 64'h0, held = 64'h0;
  always @(negedge clk) begin : cmp
    bit in_done, in_calc, e_busy;
    in_done = act && cyc == t0 + lat;
    in_calc = act && cyc > t0 && cyc < t0 + lat;
    e_busy = (!act && start && !flush && rst_n) || in_calc;
    check("busy", {63'h0, mALU_runing}, {63'h0, e_busy});
    check("valid", {63'h0, result_valid}, {63'h0, in_done});
    check("result", result, in_done ? exp_r : held);
    if (in_done) held = exp_r;
    if (!rst_n) begin
      act = 1'b0;
      held = 64'h0;
    end else if (flush || in_done) begin
      act = 1'b0;
    end else if (!act && start) begin
      act = 1'b1;
      t0 = cyc;
      lat = ref_lat(funct3, is_word, op_a, op_b);
      exp_r = ref_res(funct3, is_word, op_a, op_b);
    end
    cyc++;
  end
  task automatic run_op(input string nm, input logic [2:0] f, input logic wd, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] lit, input int elat);
    int n;
    check({nm, "_model"}, ref_res(f, wd, a, b), lit);
    @(posedge clk); #1;
    funct3 = f; is_word = wd; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (result_valid) break;
      @(posedge clk);
    end
    check({nm, "_lat"}, 64'(n), 64'(elat));
    check({nm, "_res"}, result, lit);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int pulses;
    start = 1'b1; funct3 = 3'b101; op_a = 64'd100; op_b = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1; start = 1'b0;
    check("rst_busy", {63'h0, mALU_runing}, 64'h0);
    check("rst_valid", {63'h0, result_valid}, 64'h0);
    check("rst_result", result, 64'h0);
    run_op("mul", 3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    run_op("mulhu", 3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op("divu0", 3'b101, 1'b0, 64'd100, 64'd0, '1, 1);
    run_op("remu0", 3'b111, 1'b0, 64'd100, 64'd0, 64'd100, 1);
    run_op("divw_ovf", 3'b100, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    run_op("remw_ovf", 3'b110, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0, 1);
    run_op("divw", 3'b100, 1'b1, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    run_op("remw", 3'b110, 1'b1, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    run_op("mulh", 3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, '1, 65);
    run_op("mulhsu", 3'b010, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op("mulw", 3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    run_op("mulhuw", 3'b011, 1'b1, 64'hDEAD_0000_7FFF_FFFF, 64'h1234_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    run_op("div_ovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    run_op("rem_ovf", 3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h0, 1);
    run_op("div", 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("rem", 3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 65);
    run_op("divu", 3'b101, 1'b0, '1, 64'd3, 64'h5555_5555_5555_5555, 65);
    run_op("remw0", 3'b110, 1'b1, 64'h1234_5678_8765_4321, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8765_4321, 1);
    run_op("divuw0", 3'b101, 1'b1, 64'h1234_5678_8765_4321, 64'hFFFF_FFFF_0000_0000, '1, 1);
    run_op("divuw", 3'b101, 1'b1, 64'hFFFF_FFF0, 64'h10, 64'h0FFF_FFFF, 33);
    run_op("remuw", 3'b111, 1'b1, 64'h8000_0005, 64'h10, 64'd5, 33);
    @(posedge clk); #1;
    funct3 = 3'b101; is_word = 1'b0; op_a = 64'd100; op_b = 64'd0; start = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) start = 1'b0;
      @(negedge clk);
      pulses += int'(result_valid);
      @(posedge clk); #1;
    end
    check("b2b_pulses", 64'(pulses), 64'd3);
    funct3 = 3'b100; op_a = 64'd1000; op_b = 64'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check("flush_busy", {63'h0, mALU_runing}, 64'h0);
    check("flush_valid", {63'h0, result_valid}, 64'h0);
    check("flush_hold", result, '1);
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      pulses += int'(result_valid);
    end
    check("flush_no_valid", 64'(pulses), 64'd0);
    @(posedge clk); #1;
    funct3 = 3'b100; op_a = 64'd5; op_b = 64'd1; start = 1'b1; flush = 1'b1;
    #1;
    check("idle_flush_busy", {63'h0, mALU_runing}, 64'h0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("idle_flush_ignored", {63'h0, mALU_runing}, 64'h0);
    funct3 = 3'b000; op_a = 64'd3; op_b = 64'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_busy", {63'h0, mALU_runing}, 64'h0);
    check("midrst_valid", {63'h0, result_valid}, 64'h0);
    check("midrst_result", result, 64'h0);
    run_op("mul_after_rst", 3'b000, 1'b0, 64'd3, 64'd5, 64'd15, 65);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
